// File: rtl/misr_pkg.sv
// misr_pkg: shared state type, default polynomial/seed and data-slice helper
package misr_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [23:0] DEF_POLY = 24'hE10000;
  localparam logic [23:0] DEF_SEED = '1;
  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction
endpackage

// File: rtl/misr_step.sv
// misr_step: one combinational MISR shift-and-fold step, bypassed when en is low
module misr_step #(
  parameter int W = 24,
  parameter logic [W-1:0] POLY = '0
)(
  input  logic [W-1:0] s,
  input  logic [W-1:0] d,
  input  logic         en,
  output logic [W-1:0] q
);
  assign q = en ? ({s[W-2:0], 1'b0} ^ (s[W-1] ? POLY : '0) ^ d) : s;
endmodule

// File: rtl/misr_multi.sv
// misr_multi: multi-channel MISR frame signature capture with golden compare
module misr_multi import misr_pkg::*; #(
  parameter int DATA_W = 24,
  parameter int NUM_CH = 2,
  parameter logic [DATA_W-1:0] POLY = DATA_W'(DEF_POLY),
  parameter logic [DATA_W-1:0] SEED = '1,
  parameter int CNT_W = 20
)(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     clear_i,
  input  logic                     start_i,
  input  logic [CNT_W-1:0]         frame_len_i,
  input  logic [NUM_CH-1:0]        rdy_i,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0]        expected_i,
  output logic [DATA_W-1:0]        signature_o,
  output logic [CNT_W-1:0]         count_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o
);
  state_t state, state_n;
  logic [DATA_W-1:0] sig, sig_n;
  logic [CNT_W-1:0] count, count_n, len, len_n;
  logic [DATA_W-1:0] chain [NUM_CH+1];
  logic beat, start_ok, last;
  assign chain[0] = sig;
  // valid channels fold in ascending order; invalid ones pass the signature through
  for (genvar g = 0; g < NUM_CH; g++) begin : g_step
    misr_step #(.W(DATA_W), .POLY(POLY)) u_step (
      .s(chain[g]),
      .d(data_i[slice_lo(g, DATA_W) +: DATA_W]),
      .en(rdy_i[g]),
      .q(chain[g+1])
    );
  end
  always_comb begin
    beat = en_i && |rdy_i;
    start_ok = start_i && frame_len_i != '0 && state != RUN;
    last = count + CNT_W'(1) == len;
    state_n = state;
    sig_n = sig;
    count_n = count;
    len_n = len;
    if (start_ok) begin
      state_n = RUN;
      sig_n = SEED;
      count_n = '0;
      len_n = frame_len_i;
    end else if (state == RUN && beat) begin
      sig_n = chain[NUM_CH];
      count_n = count + CNT_W'(1);
      state_n = last ? DONE : RUN;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state <= IDLE;
      sig <= SEED;
      count <= '0;
      len <= '0;
    end else begin
      state <= state_n;
      sig <= sig_n;
      count <= count_n;
      len <= len_n;
    end
  end
  assign signature_o = sig;
  assign count_o = count;
  assign busy_o = state == RUN;
  assign done_o = state == DONE;
  assign pass_o = state == DONE && sig == expected_i;
endmodule

// File: tb/tb_misr_multi.sv
// tb_misr_multi: directed and randomized checks of misr_multi against a behavioural model
module tb_misr_multi;
  logic clk = 0;
  logic rst, en, clr, start;
  logic [19:0] flen;
  logic [1:0] rdy;
  logic [15:0] data;
  logic [7:0] expected;
  logic [7:0] sig, sig_ff;
  logic [19:0] cnt, cnt_ff;
  logic busy, done, pass, busy_ff, done_ff, pass_ff;
  int checks = 0, passed = 0;
  int m_st = 0, m_cnt = 0, m_len = 0;
  logic [7:0] m_sig = 8'h00;

  always #5 clk = ~clk;

  misr_multi #(.DATA_W(8), .NUM_CH(2), .POLY(8'h1D), .SEED(8'h00), .CNT_W(20)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .start_i(start),
    .frame_len_i(flen), .rdy_i(rdy), .data_i(data), .expected_i(expected),
    .signature_o(sig), .count_o(cnt), .busy_o(busy), .done_o(done), .pass_o(pass)
  );

  misr_multi #(.DATA_W(8), .NUM_CH(2), .POLY(8'h1D), .SEED(8'hFF), .CNT_W(20)) dut_ff (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .start_i(start),
    .frame_len_i(flen), .rdy_i(rdy), .data_i(data), .expected_i(expected),
    .signature_o(sig_ff), .count_o(cnt_ff), .busy_o(busy_ff), .done_o(done_ff), .pass_o(pass_ff)
  );

  function automatic logic [7:0] step(input logic [7:0] s, input logic [7:0] d);
    int t;
    t = int'(s) * 2;
    if (t > 255) t = (t - 256) ^ 'h1D;
    return 8'(t) ^ d;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst || clr) begin
      m_st = 0; m_sig = 8'h00; m_cnt = 0;
    end else if (m_st != 1 && start && flen != 0) begin
      m_st = 1; m_sig = 8'h00; m_cnt = 0; m_len = int'(flen);
    end else if (m_st == 1 && en && rdy != 0) begin
      for (int k = 0; k < 2; k++)
        if (rdy[k]) m_sig = step(m_sig, data[k*8 +: 8]);
      m_cnt++;
      if (m_cnt == m_len) m_st = 2;
    end
    #1;
  endtask

  task automatic drive(input logic s, input logic [19:0] fl, input logic e,
                       input logic [1:0] r, input logic [15:0] d);
    start = s; flen = fl; en = e; rdy = r; data = d;
    tick();
  endtask

  task automatic test_reset();
    rst = 1;
    drive(0, 0, 0, 0, 0);
    checks++; if (sig !== 8'h00) $display("FAIL reset_sig got %h want 00", sig); else passed++;
    checks++; if (sig_ff !== 8'hFF) $display("FAIL reset_sig_ff got %h want ff", sig_ff); else passed++;
    checks++; if ({busy, done, pass, cnt} !== 23'd0) $display("FAIL reset_flags got %b/%b/%b cnt %0d want 0", busy, done, pass, cnt); else passed++;
    rst = 0;
  endtask

  task automatic test_single();
    drive(1, 1, 0, 0, 0);
    checks++; if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else passed++;
    drive(0, 0, 1, 2'b01, 16'hEE5A);
    checks++; if (done !== 1'b1) $display("FAIL single_done got %b want 1", done); else passed++;
    checks++; if (sig !== 8'h5A) $display("FAIL single_sig got %h want 5a", sig); else passed++;
    checks++; if (cnt !== 20'd1) $display("FAIL single_cnt got %0d want 1", cnt); else passed++;
    expected = 8'h5A; #1;
    checks++; if (pass !== 1'b1) $display("FAIL single_pass got %b want 1", pass); else passed++;
    expected = 8'h5B; #1;
    checks++; if (pass !== 1'b0) $display("FAIL single_nopass got %b want 0", pass); else passed++;
    drive(0, 0, 1, 2'b11, 16'h1234);
    checks++; if (sig !== 8'h5A || cnt !== 20'd1) $display("FAIL done_frozen got %h/%0d want 5a/1", sig, cnt); else passed++;
  endtask

  task automatic test_two_beat();
    drive(1, 2, 0, 0, 0);
    drive(0, 0, 1, 2'b01, 16'h0001);
    checks++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL two_mid got done %b busy %b want 0/1", done, busy); else passed++;
    drive(1, 7, 1, 2'b01, 16'h0000);
    checks++; if (sig !== 8'h02 || done !== 1'b1) $display("FAIL two_end got %h done %b want 02/1", sig, done); else passed++;
  endtask

  task automatic test_both_ch();
    drive(1, 1, 0, 0, 0);
    drive(0, 0, 1, 2'b11, 16'h0001);
    checks++; if (sig !== 8'h02 || cnt !== 20'd1) $display("FAIL both_ch got %h/%0d want 02/1", sig, cnt); else passed++;
  endtask

  task automatic test_en_gap();
    drive(1, 3, 0, 0, 0);
    drive(0, 0, 1, 2'b01, 16'h0011);
    drive(0, 0, 0, 2'b11, 16'h7777);
    drive(0, 0, 0, 2'b11, 16'h7777);
    checks++; if (cnt !== 20'd1 || done !== 1'b0 || sig !== 8'h11) $display("FAIL en_gap got %0d/%b/%h want 1/0/11", cnt, done, sig); else passed++;
    drive(0, 0, 1, 2'b10, 16'h2200);
    checks++; if (done !== 1'b0) $display("FAIL en_gap_early got %b want 0", done); else passed++;
    drive(0, 0, 1, 2'b01, 16'h0033);
    checks++; if (done !== 1'b1 || cnt !== 20'd3 || sig !== m_sig) $display("FAIL en_gap_end got %b/%0d/%h want 1/3/%h", done, cnt, sig, m_sig); else passed++;
  endtask

  task automatic test_clear();
    drive(1, 5, 0, 0, 0);
    drive(0, 0, 1, 2'b01, 16'h00AB);
    clr = 1;
    drive(1, 5, 1, 2'b11, 16'h1234);
    clr = 0;
    checks++; if (sig !== 8'h00 || cnt !== 20'd0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL clear got %h/%0d/%b/%b want 00/0/0/0", sig, cnt, busy, done); else passed++;
  endtask

  task automatic test_reset_mid();
    drive(1, 4, 0, 0, 0);
    drive(0, 0, 1, 2'b11, 16'h5566);
    drive(0, 0, 1, 2'b01, 16'h0077);
    rst = 1;
    drive(1, 4, 1, 2'b01, 16'h0001);
    rst = 0;
    checks++; if (sig_ff !== 8'hFF || cnt_ff !== 20'd0) $display("FAIL rst_mid got %h/%0d want ff/0", sig_ff, cnt_ff); else passed++;
    checks++; if ({busy_ff, done_ff, pass_ff} !== 3'b000) $display("FAIL rst_mid_flags got %b%b%b want 000", busy_ff, done_ff, pass_ff); else passed++;
    drive(1, 0, 1, 2'b01, 16'h0001);
    checks++; if (busy_ff !== 1'b0 || busy !== 1'b0) $display("FAIL zero_len got %b/%b want 0/0", busy_ff, busy); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clr = $urandom_range(0, 39) == 0;
      drive($urandom_range(0, 5) == 0, 20'($urandom_range(0, 6)), $urandom_range(0, 3) != 0,
            2'($urandom), 16'($urandom));
      clr = 0;
      expected = $urandom_range(0, 1) ? m_sig : 8'($urandom);
      #1;
      checks++; if (sig !== m_sig) $display("FAIL rnd_sig cyc %0d got %h want %h", i, sig, m_sig); else passed++;
      checks++; if (cnt !== 20'(m_cnt)) $display("FAIL rnd_cnt cyc %0d got %0d want %0d", i, cnt, m_cnt); else passed++;
      checks++; if (busy !== (m_st == 1)) $display("FAIL rnd_busy cyc %0d got %b want %b", i, busy, m_st == 1); else passed++;
      checks++; if (done !== (m_st == 2)) $display("FAIL rnd_done cyc %0d got %b want %b", i, done, m_st == 2); else passed++;
      checks++; if (pass !== (m_st == 2 && expected == m_sig)) $display("FAIL rnd_pass cyc %0d got %b want %b", i, pass, m_st == 2 && expected == m_sig); else passed++;
    end
  endtask

  initial begin
    rst = 1; en = 0; clr = 0; start = 0; flen = 0; rdy = 0; data = 0; expected = 0;
    test_reset();
    test_single();
    test_two_beat();
    test_both_ch();
    test_en_gap();
    test_clear();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
